// File: rtl/tiny_oram_port_arbiter.sv
// Round-robin front end that shares one TinyORAM user interface among
// NumPorts clients. One request is in flight at a time; command, write beats
// and read beats are passed straight through to/from the owning client.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | no owner; picks the next requester starting from the RR pointer
// ST_CMD   | owner's command presented to the core, waiting for CmdReady
// ST_WDATA | BlockWords write beats forwarded from owner to core
// ST_RDATA | BlockWords read beats forwarded from core to owner
module tiny_oram_port_arbiter #(
    parameter int NumPorts     = 4,
    parameter int ORAMU        = 32,
    parameter int ORAMB        = 512,
    parameter int FEDWidth     = 64,
    parameter int BECMDWidth   = 2,
    parameter int PortAddrMode = 1
) (
    input  logic                           Clock,
    input  logic                           Reset,
    input  logic [NumPorts*BECMDWidth-1:0] PortCmd,
    input  logic [NumPorts*ORAMU-1:0]      PortPAddr,
    input  logic [NumPorts-1:0]            PortCmdValid,
    output logic [NumPorts-1:0]            PortCmdReady,
    input  logic [NumPorts*FEDWidth-1:0]   PortDataIn,
    input  logic [NumPorts-1:0]            PortDataInValid,
    output logic [NumPorts-1:0]            PortDataInReady,
    output logic [FEDWidth-1:0]            PortDataOut,
    output logic [NumPorts-1:0]            PortDataOutValid,
    input  logic [NumPorts-1:0]            PortDataOutReady,
    output logic [BECMDWidth-1:0]          Cmd,
    output logic [ORAMU-1:0]               PAddr,
    output logic                           CmdValid,
    input  logic                           CmdReady,
    output logic [FEDWidth-1:0]            DataIn,
    output logic                           DataInValid,
    input  logic                           DataInReady,
    input  logic [FEDWidth-1:0]            DataOut,
    input  logic                           DataOutValid,
    output logic                           DataOutReady,
    output logic [NumPorts-1:0]            Grant
);

    localparam int P          = $clog2(NumPorts);
    localparam int BlockWords = ORAMB / FEDWidth;
    localparam int CntW       = $clog2(BlockWords) + 1;
    localparam logic [CntW-1:0]       LastBeat   = CntW'(BlockWords - 1);
    localparam logic [BECMDWidth-1:0] CmdUpdate  = BECMDWidth'(0);
    localparam logic [BECMDWidth-1:0] CmdAppend  = BECMDWidth'(1);
    localparam logic [ORAMU-1:0]      LowAddrMsk = {ORAMU{1'b1}} >> P;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_WDATA = 2'd2,
        ST_RDATA = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [P-1:0]    owner, owner_nxt;
    logic [P-1:0]    rr, rr_nxt;
    logic [CntW-1:0] beat_cnt, beat_cnt_nxt;

    logic [BECMDWidth-1:0] cmd_arr   [NumPorts];
    logic [ORAMU-1:0]      paddr_arr [NumPorts];
    logic [FEDWidth-1:0]   din_arr   [NumPorts];

    genvar g;
    generate
        for (g = 0; g < NumPorts; g++) begin : g_unpack
            assign cmd_arr[g]   = PortCmd[g*BECMDWidth +: BECMDWidth];
            assign paddr_arr[g] = PortPAddr[g*ORAMU +: ORAMU];
            assign din_arr[g]   = PortDataIn[g*FEDWidth +: FEDWidth];
        end
    endgenerate

    logic [P-1:0]     pick;
    logic             pick_vld;
    logic [ORAMU-1:0] paddr_own;
    logic             own_is_write;

    // Owner ID replaces the top P address bits so each client gets its own region.
    assign paddr_own = (PortAddrMode != 0)
                     ? ({owner, {(ORAMU-P){1'b0}}} | (paddr_arr[owner] & LowAddrMsk))
                     : paddr_arr[owner];

    assign own_is_write = (cmd_arr[owner] == CmdUpdate) || (cmd_arr[owner] == CmdAppend);

    // Read data is broadcast; only the owner's valid bit qualifies it.
    assign PortDataOut = DataOut;

    // First requester at or after the RR pointer, wrapping around.
    always_comb begin
        pick     = rr;
        pick_vld = 1'b0;
        for (int i = 0; i < NumPorts; i++) begin
            if (!pick_vld && PortCmdValid[rr + P'(i)]) begin
                pick     = rr + P'(i);
                pick_vld = 1'b1;
            end
        end
    end

    // Next-state logic and owner-routed handshake muxing.
    always_comb begin
        state_nxt        = state;
        owner_nxt        = owner;
        rr_nxt           = rr;
        beat_cnt_nxt     = beat_cnt;
        Cmd              = '0;
        PAddr            = '0;
        CmdValid         = 1'b0;
        PortCmdReady     = '0;
        DataIn           = '0;
        DataInValid      = 1'b0;
        PortDataInReady  = '0;
        DataOutReady     = 1'b0;
        PortDataOutValid = '0;
        Grant            = '0;
        case (state)
            ST_IDLE: begin
                if (pick_vld) begin
                    owner_nxt = pick;
                    state_nxt = ST_CMD;
                end
            end
            ST_CMD: begin
                Grant[owner]        = 1'b1;
                Cmd                 = cmd_arr[owner];
                PAddr               = paddr_own;
                CmdValid            = PortCmdValid[owner];
                PortCmdReady[owner] = CmdReady;
                if (PortCmdValid[owner] && CmdReady) begin
                    rr_nxt       = owner + P'(1);
                    beat_cnt_nxt = '0;
                    state_nxt    = own_is_write ? ST_WDATA : ST_RDATA;
                end
            end
            ST_WDATA: begin
                Grant[owner]           = 1'b1;
                DataIn                 = din_arr[owner];
                DataInValid            = PortDataInValid[owner];
                PortDataInReady[owner] = DataInReady;
                if (PortDataInValid[owner] && DataInReady) begin
                    beat_cnt_nxt = beat_cnt + CntW'(1);
                    if (beat_cnt == LastBeat) begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_RDATA: begin
                Grant[owner]            = 1'b1;
                DataOutReady            = PortDataOutReady[owner];
                PortDataOutValid[owner] = DataOutValid;
                if (DataOutValid && PortDataOutReady[owner]) begin
                    beat_cnt_nxt = beat_cnt + CntW'(1);
                    if (beat_cnt == LastBeat) begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, owner, RR pointer and beat counter registers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= ST_IDLE;
            owner    <= '0;
            rr       <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            rr       <= rr_nxt;
            beat_cnt <= beat_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_tiny_oram_port_arbiter.sv
// Bench for tiny_oram_port_arbiter: directed scenarios plus a random phase,
// all checked against a transaction-level model of clients, core and the
// round-robin grant rule. A second instance runs with address pass-through.
module tb_tiny_oram_port_arbiter;

    localparam int N  = 4;
    localparam int U  = 32;
    localparam int W  = 64;
    localparam int CW = 2;
    localparam int BW = 8;

    logic clk = 1'b0;
    logic Reset;
    always #5 clk = ~clk;

    logic [N*CW-1:0] PortCmd;
    logic [N*U-1:0]  PortPAddr;
    logic [N-1:0]    PortCmdValid, PortDataInValid, PortDataOutReady;
    logic [N*W-1:0]  PortDataIn;
    logic            CmdReady, DataInReady, DataOutValid;
    logic [W-1:0]    DataOut;

    logic [N-1:0]  PortCmdReady, PortDataInReady, PortDataOutValid, Grant;
    logic [W-1:0]  PortDataOut, DataIn;
    logic [CW-1:0] Cmd;
    logic [U-1:0]  PAddr;
    logic          CmdValid, DataInValid, DataOutReady;

    logic [N-1:0]  m0_PortCmdReady, m0_PortDataInReady, m0_PortDataOutValid, m0_Grant;
    logic [W-1:0]  m0_PortDataOut, m0_DataIn;
    logic [CW-1:0] m0_Cmd;
    logic [U-1:0]  m0_PAddr;
    logic          m0_CmdValid, m0_DataInValid, m0_DataOutReady;

    tiny_oram_port_arbiter #(.NumPorts(N), .ORAMU(U), .ORAMB(512), .FEDWidth(W),
                             .BECMDWidth(CW), .PortAddrMode(1)) u_dut (
        .Clock(clk), .Reset(Reset),
        .PortCmd(PortCmd), .PortPAddr(PortPAddr), .PortCmdValid(PortCmdValid),
        .PortCmdReady(PortCmdReady), .PortDataIn(PortDataIn),
        .PortDataInValid(PortDataInValid), .PortDataInReady(PortDataInReady),
        .PortDataOut(PortDataOut), .PortDataOutValid(PortDataOutValid),
        .PortDataOutReady(PortDataOutReady), .Cmd(Cmd), .PAddr(PAddr),
        .CmdValid(CmdValid), .CmdReady(CmdReady), .DataIn(DataIn),
        .DataInValid(DataInValid), .DataInReady(DataInReady), .DataOut(DataOut),
        .DataOutValid(DataOutValid), .DataOutReady(DataOutReady), .Grant(Grant)
    );

    tiny_oram_port_arbiter #(.NumPorts(N), .ORAMU(U), .ORAMB(512), .FEDWidth(W),
                             .BECMDWidth(CW), .PortAddrMode(0)) u_dut_m0 (
        .Clock(clk), .Reset(Reset),
        .PortCmd(PortCmd), .PortPAddr(PortPAddr), .PortCmdValid(PortCmdValid),
        .PortCmdReady(m0_PortCmdReady), .PortDataIn(PortDataIn),
        .PortDataInValid(PortDataInValid), .PortDataInReady(m0_PortDataInReady),
        .PortDataOut(m0_PortDataOut), .PortDataOutValid(m0_PortDataOutValid),
        .PortDataOutReady(PortDataOutReady), .Cmd(m0_Cmd), .PAddr(m0_PAddr),
        .CmdValid(m0_CmdValid), .CmdReady(CmdReady), .DataIn(m0_DataIn),
        .DataInValid(m0_DataInValid), .DataInReady(DataInReady), .DataOut(DataOut),
        .DataOutValid(DataOutValid), .DataOutReady(m0_DataOutReady), .Grant(m0_Grant)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // stimulus knobs (percent)
    int p_req, p_cready, p_dready, p_dval, p_oval, p_ordy, p_stray, p_drop;
    bit ordy_toggle;

    // client side
    logic        req_v    [N];
    logic [1:0]  req_cmd  [N];
    logic [31:0] req_addr [N];
    int          req_tag  [N];
    logic        port_act [N];
    logic        port_wr  [N];
    int          wbeat    [N];
    int          rbeat    [N];

    // transaction-level arbiter/core model
    bit m_busy, m_cmd_done, m_wr;
    int m_owner, m_beat, m_tag, m_txn, rr_m, n_done, cyc;
    int grant_q [$];

    // observations for directed checks
    logic [1:0]  last_cmd;
    logic [31:0] last_paddr, last_m0_paddr;
    logic [3:0]  last_grant;
    int          core_beats, last_beats;

    function automatic logic [63:0] wdata(input int p, input int tag, input int beat);
        return {8'(p), 24'(tag), 32'(beat)};
    endfunction

    function automatic logic [63:0] rdata(input int txn, input int beat);
        return {16'hDA7A, 16'(txn), 32'(beat)};
    endfunction

    function automatic int rr_pick(input logic [N-1:0] pend, input int rr);
        for (int i = 0; i < N; i++)
            if (pend[(rr + i) % N]) return (rr + i) % N;
        return 0;
    endfunction

    task automatic quiet();
        PortCmdValid = '0; PortDataInValid = '0; PortDataOutReady = '0;
        PortCmd = '0; PortPAddr = '0; PortDataIn = '0;
        CmdReady = 1'b0; DataInReady = 1'b0; DataOutValid = 1'b0; DataOut = '0;
    endtask

    task automatic model_clear();
        m_busy = 0; m_cmd_done = 0; m_wr = 0; m_beat = 0; rr_m = 0;
        for (int p = 0; p < N; p++) begin
            req_v[p] = 0; port_act[p] = 0; port_wr[p] = 0; wbeat[p] = 0; rbeat[p] = 0;
        end
    endtask

    task automatic post_req(input int p, input logic [1:0] c, input logic [31:0] a);
        req_v[p] = 1; req_cmd[p] = c; req_addr[p] = a; req_tag[p]++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        Reset = 1'b1;
        quiet();
        model_clear();
        @(negedge clk);
        Reset = 1'b0;
        #1;
        chk("rst_outs", {CmdValid, PortCmdReady, DataInValid, PortDataInReady,
                         DataOutReady, PortDataOutValid, Grant}, '0);
        chk("rst_m0_outs", {m0_CmdValid, m0_PortCmdReady, m0_DataInValid, m0_PortDataInReady,
                            m0_DataOutReady, m0_PortDataOutValid, m0_Grant}, '0);
        chk("rst_dout", PortDataOut, DataOut);
    endtask

    task automatic finish_txn();
        chk("beats_core", core_beats, BW);
        chk("beats_client", m_wr ? wbeat[m_owner] : rbeat[m_owner], BW);
        last_beats = core_beats;
        port_act[m_owner] = 0;
        port_wr[m_owner]  = 0;
        m_busy = 0;
        n_done++;
    endtask

    task automatic step();
        logic [3:0]  own, g_exp, e_pcr, e_pdir, e_pdov;
        logic        e_cv, e_div, e_dor, ph_cmd, ph_wr, ph_rd;
        logic [1:0]  o2;
        @(negedge clk);
        cyc++;
        for (int p = 0; p < N; p++)
            if (!req_v[p] && !port_act[p] && ($urandom_range(99) < p_req))
                post_req(p, 2'($urandom_range(3)), $urandom);
        for (int p = 0; p < N; p++) begin
            PortCmd[p*CW +: CW]  = req_cmd[p];
            PortPAddr[p*U +: U]  = req_addr[p];
            PortCmdValid[p]      = req_v[p] && !($urandom_range(99) < p_drop);
            PortDataInValid[p]   = port_wr[p] && (wbeat[p] < BW) && ($urandom_range(99) < p_dval);
            PortDataIn[p*W +: W] = wdata(p, req_tag[p], wbeat[p]);
            PortDataOutReady[p]  = ordy_toggle ? cyc[0] : ($urandom_range(99) < p_ordy);
        end
        CmdReady    = $urandom_range(99) < p_cready;
        DataInReady = $urandom_range(99) < p_dready;
        if (m_busy && m_cmd_done && !m_wr) begin
            DataOut      = rdata(m_txn, m_beat);
            DataOutValid = $urandom_range(99) < p_oval;
        end else begin
            DataOut      = {$urandom, $urandom};
            DataOutValid = $urandom_range(99) < p_stray;
        end
        #1;
        o2     = m_owner[1:0];
        own    = 4'b0001 << o2;
        g_exp  = m_busy ? own : 4'b0000;
        ph_cmd = m_busy && !m_cmd_done;
        ph_wr  = m_busy && m_cmd_done && m_wr;
        ph_rd  = m_busy && m_cmd_done && !m_wr;
        e_cv   = ph_cmd && PortCmdValid[o2];
        e_pcr  = (ph_cmd && CmdReady) ? own : 4'b0000;
        e_div  = ph_wr && PortDataInValid[o2];
        e_pdir = (ph_wr && DataInReady) ? own : 4'b0000;
        e_dor  = ph_rd && PortDataOutReady[o2];
        e_pdov = (ph_rd && DataOutValid) ? own : 4'b0000;

        chk("grant", Grant, g_exp);
        chk("m0_grant", m0_Grant, g_exp);
        chk("hs", {CmdValid, PortCmdReady, DataInValid, PortDataInReady, DataOutReady, PortDataOutValid},
                  {e_cv, e_pcr, e_div, e_pdir, e_dor, e_pdov});
        chk("m0_hs", {m0_CmdValid, m0_PortCmdReady, m0_DataInValid, m0_PortDataInReady,
                      m0_DataOutReady, m0_PortDataOutValid}, {e_cv, e_pcr, e_div, e_pdir, e_dor, e_pdov});
        chk("dout_pass", PortDataOut, DataOut);
        chk("m0_dout_pass", m0_PortDataOut, DataOut);
        if (e_cv) begin
            chk("cmd", Cmd, req_cmd[o2]);
            chk("m0_cmd", m0_Cmd, req_cmd[o2]);
            chk("paddr", PAddr, {o2, req_addr[o2][29:0]});
            chk("m0_paddr", m0_PAddr, req_addr[o2]);
        end
        if (e_div) begin
            chk("din", DataIn, wdata(m_owner, m_tag, m_beat));
            chk("m0_din", m0_DataIn, wdata(m_owner, m_tag, m_beat));
        end
        if (!m_busy) begin
            chk("idle_cmd_addr", {Cmd, PAddr}, '0);
            chk("idle_din", DataIn, '0);
            chk("m0_idle_zero", {m0_Cmd, m0_PAddr, m0_DataIn[31:0] | m0_DataIn[63:32]}, '0);
        end

        // observations from the DUT side
        if (CmdValid && CmdReady) begin
            last_cmd = Cmd; last_paddr = PAddr; last_m0_paddr = m0_PAddr; last_grant = Grant;
            core_beats = 0;
        end
        if ((DataInValid && DataInReady) || (DataOutValid && DataOutReady)) core_beats++;
        for (int p = 0; p < N; p++) begin
            if (PortDataOutValid[p] && PortDataOutReady[p]) begin
                chk("rdata", PortDataOut, rdata(m_txn, rbeat[p]));
                rbeat[p]++;
            end
            if (PortDataInValid[p] && PortDataInReady[p]) wbeat[p]++;
        end

        // model advance for the coming edge
        if (!m_busy) begin
            if (PortCmdValid != '0) begin
                m_owner = rr_pick(PortCmdValid, rr_m);
                m_busy = 1; m_cmd_done = 0; m_beat = 0;
                grant_q.push_back(m_owner);
            end
        end else if (ph_cmd) begin
            if (PortCmdValid[o2] && CmdReady) begin
                m_cmd_done = 1;
                m_wr   = (req_cmd[o2] < 2);
                m_tag  = req_tag[o2];
                rr_m   = (m_owner + 1) % N;
                m_txn++;
                req_v[o2] = 0; port_act[o2] = 1; port_wr[o2] = m_wr;
                wbeat[o2] = 0; rbeat[o2] = 0;
            end
        end else if (ph_wr) begin
            if (PortDataInValid[o2] && DataInReady) m_beat++;
            if (m_beat == BW) finish_txn();
        end else begin
            if (DataOutValid && PortDataOutReady[o2]) m_beat++;
            if (m_beat == BW) finish_txn();
        end
    endtask

    task automatic run_txns(input int n, input int budget);
        int start;
        start = n_done;
        for (int c = 0; c < budget && n_done < start + n; c++) step();
        if (n_done < start + n) chk("txn_timeout", n_done - start, n);
    endtask

    task automatic set_ideal();
        p_req = 0; p_cready = 100; p_dready = 100; p_dval = 100; p_oval = 100;
        p_ordy = 100; p_stray = 0; p_drop = 0; ordy_toggle = 0;
    endtask

    initial begin
        Reset = 1'b1;
        quiet();
        cyc = 0; n_done = 0; m_txn = 0; m_owner = 0; m_tag = 0; core_beats = 0; last_beats = 0;
        for (int p = 0; p < N; p++) begin req_tag[p] = 0; req_cmd[p] = 0; req_addr[p] = 0; end
        model_clear();
        set_ideal();
        repeat (2) @(negedge clk);

        // Port 2 Append with address partitioning, then RR pointer effect.
        do_reset();
        post_req(2, 2'd1, 32'h0000_00AA);
        run_txns(1, 40);
        chk("t1_cmd", last_cmd, 2'd1);
        chk("t1_paddr", last_paddr, 32'h8000_00AA);
        chk("t1_grant", last_grant, 4'b0100);
        chk("t1_beats", last_beats, BW);
        grant_q.delete();
        post_req(0, 2'd2, 32'h11);
        post_req(3, 2'd2, 32'h33);
        run_txns(2, 80);
        chk("t1_rr_first", grant_q.size() >= 2 ? grant_q[0] : -1, 3);
        chk("t1_rr_second", grant_q.size() >= 2 ? grant_q[1] : -1, 0);

        // All four ports read together from reset.
        do_reset();
        grant_q.delete();
        for (int p = 0; p < N; p++) post_req(p, 2'd2, 32'h100 + p);
        run_txns(4, 200);
        chk("t2_ngrants", grant_q.size(), 4);
        for (int i = 0; i < N; i++)
            chk("t2_order", grant_q.size() > i ? grant_q[i] : -1, i);

        // Port 3 read with the client ready toggling.
        do_reset();
        ordy_toggle = 1;
        post_req(3, 2'd3, 32'h3);
        run_txns(1, 60);
        chk("t3_beats", last_beats, BW);
        ordy_toggle = 0;

        // Address pass-through instance.
        do_reset();
        post_req(1, 2'd0, 32'hC000_1234);
        run_txns(1, 40);
        chk("t4_m0_paddr", last_m0_paddr, 32'hC000_1234);
        chk("t4_m1_paddr", last_paddr, 32'h4000_1234);

        // Reset in the middle of a port 0 Update, then a fresh request.
        do_reset();
        post_req(0, 2'd0, 32'h77);
        for (int c = 0; c < 40 && wbeat[0] < 4; c++) step();
        chk("t5_reach_beat4", wbeat[0], 4);
        do_reset();
        grant_q.delete();
        post_req(1, 2'd2, 32'h55);
        run_txns(1, 40);
        chk("t5_regrant", grant_q.size() > 0 ? grant_q[0] : -1, 1);

        // Stray core read data while idle.
        do_reset();
        p_stray = 100;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("t6_stray_valid", DataOutValid, 1'b1);
            chk("t6_dor", DataOutReady, 1'b0);
            chk("t6_pdov", PortDataOutValid, 4'b0000);
        end

        // Random traffic with backpressure, stray data and valid drops.
        do_reset();
        p_req = 30; p_cready = 60; p_dready = 70; p_dval = 70; p_oval = 70;
        p_ordy = 70; p_stray = 20; p_drop = 10;
        begin
            int start;
            start = n_done;
            repeat (3000) step();
            chk("rand_progress", (n_done - start) >= 30, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
